// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that time-shares one sequential Booth multiplier among N_REQ requesters.
// Operands go out on a single bus (start, multiplicand, multiplier); a watchdog bounds each job.
module booth_mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic                     resp_err,
  output logic                     mult_start,
  output logic [WIDTH-1:0]         mult_data,
  input  logic                     mult_done,
  input  logic [2*WIDTH-1:0]       mult_product,
  output logic                     mult_rst,
  output logic                     busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, LOAD_M, LOAD_Q, BUSY, RESP, RECOVER} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          owner;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_vld;
  logic [CNT_W-1:0]          wd_cnt;
  logic signed [WIDTH-1:0]   a_lat;
  logic signed [WIDTH-1:0]   b_lat;

  function automatic logic [IDX_W-1:0] wrap_idx(input int j);
    return (j >= N_REQ) ? IDX_W'(j - N_REQ) : IDX_W'(j);
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Scan from the highest offset down so the bit closest to rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[wrap_idx(int'(rr_ptr) + i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(int'(rr_ptr) + i);
      end
    end
  end

  assign mult_rst = rst | (state == RECOVER);

  always_ff @(posedge clk) begin
    if (state == IDLE && pick_vld) begin
      a_lat <= req_a[pick_idx*WIDTH +: WIDTH];
      b_lat <= req_b[pick_idx*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      grant        <= '0;
      resp_valid   <= '0;
      resp_product <= '0;
      resp_err     <= 1'b0;
      mult_start   <= 1'b0;
      mult_data    <= '0;
      busy         <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner      <= pick_idx;
            grant      <= onehot(pick_idx);
            mult_start <= 1'b1;
            mult_data  <= '0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mult_start <= 1'b0;
          mult_data  <= a_lat;
          state      <= LOAD_M;
        end
        LOAD_M: begin
          mult_data <= b_lat;
          state     <= LOAD_Q;
        end
        LOAD_Q: begin
          mult_data <= '0;
          wd_cnt    <= '0;
          state     <= BUSY;
        end
        // A done arriving on the last watchdog cycle still counts as success.
        BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (mult_done) begin
            resp_product <= mult_product;
            resp_err     <= 1'b0;
            resp_valid   <= onehot(owner);
            state        <= RESP;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_product <= '0;
            resp_err     <= 1'b1;
            resp_valid   <= onehot(owner);
            state        <= RESP;
          end
        end
        RESP: begin
          resp_valid <= '0;
          rr_ptr     <= next_ptr(owner);
          grant      <= '0;
          state      <= RECOVER;
        end
        RECOVER: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: behavioural multiplier model plus a round-robin/product
// reference model driven with randomized operands and masks.
module tb_booth_mult_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     grant, resp_valid;
  logic [2*W-1:0]   resp_product;
  logic             resp_err, mult_start, mult_rst, busy;
  logic [W-1:0]     mult_data;
  logic             mult_done;
  logic [2*W-1:0]   mult_product;

  int checks = 0;
  int failures = 0;
  int ref_rr = 0;

  booth_mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .resp_valid(resp_valid), .resp_product(resp_product),
    .resp_err(resp_err), .mult_start(mult_start), .mult_data(mult_data),
    .mult_done(mult_done), .mult_product(mult_product), .mult_rst(mult_rst),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural sequential multiplier: start, then A, then B on the bus; done after mdl_lat cycles.
  int                  mdl_lat = 5;
  logic                stale_done = 1'b0;
  logic                m_done = 1'b0;
  logic [2*W-1:0]      m_prod = '0;
  logic signed [W-1:0] m_a = '0;
  logic signed [W-1:0] m_b = '0;
  int                  m_phase = 0;
  int                  m_cnt = 0;

  always @(posedge clk) begin
    if (mult_rst) begin
      m_done  <= 1'b0;
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (mult_start) m_phase <= 1;
        1: begin m_a <= mult_data; m_phase <= 2; end
        2: begin m_b <= mult_data; m_phase <= 3; m_cnt <= 0; end
        3: begin
          m_cnt <= m_cnt + 1;
          if (mdl_lat >= 0 && m_cnt + 1 >= mdl_lat) begin
            m_done  <= 1'b1;
            m_prod  <= 32'(m_a * m_b);
            m_phase <= 4;
          end
        end
        default: ;
      endcase
    end
  end

  assign mult_done    = m_done | stale_done;
  assign mult_product = m_prod;

  function automatic int pick(input logic [N-1:0] m, input int rr);
    for (int k = 0; k < N; k++) begin
      if (m[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [2*W-1:0] exp_prod(input int i);
    logic signed [W-1:0] a, b;
    a = req_a[i*W +: W];
    b = req_b[i*W +: W];
    return 32'(a * b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i);
    req_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
    req_b[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
  endtask

  task automatic idle_wait();
    for (int c = 0; c < 40; c++) begin
      if (busy === 1'b0) return;
      tick();
    end
    checks++; failures++;
    $display("FAIL idle_wait busy=%b required=0", busy);
  endtask

  task automatic wait_resp(output int who, output logic [2*W-1:0] prod, output logic err,
                           output int nt);
    who = -1; prod = '0; err = 1'b0; nt = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      nt++;
      if (resp_valid !== '0) begin
        for (int k = 0; k < N; k++) if (resp_valid[k]) who = k;
        prod = resp_product;
        err  = resp_err;
        checks++;
        if ($countones(resp_valid) != 1 || grant !== resp_valid) begin
          failures++;
          $display("FAIL resp_onehot resp_valid=%b grant=%b required one-hot and equal",
                   resp_valid, grant);
        end
        ref_rr = (who + 1) % N;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL resp_wait no resp_valid within 400 cycles");
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    tick(); tick(); tick();
    checks++;
    if (grant !== '0 || resp_valid !== '0 || busy !== 1'b0 || mult_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl grant=%b resp_valid=%b busy=%b start=%b required all 0",
               grant, resp_valid, busy, mult_start);
    end
    checks++;
    if (resp_product !== '0 || resp_err !== 1'b0 || mult_data !== '0) begin
      failures++;
      $display("FAIL reset_data prod=%h err=%b data=%h required 0", resp_product, resp_err,
               mult_data);
    end
    checks++;
    if (mult_rst !== 1'b1) begin
      failures++; $display("FAIL reset_mult_rst got=%b required=1", mult_rst);
    end
    rst = 1'b0; ref_rr = 0;
    tick();
    checks++;
    if (mult_rst !== 1'b0) begin
      failures++; $display("FAIL reset_release_mult_rst got=%b required=0", mult_rst);
    end
  endtask

  task automatic test_single_job();
    int who, nt; logic [2*W-1:0] prod; logic err;
    req_a[0 +: W] = 16'd7; req_b[0 +: W] = 16'hFFFD; mdl_lat = 19; req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001 || mult_start !== 1'b1 || mult_data !== 16'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_issue grant=%b start=%b data=%h busy=%b required 0001/1/0000/1",
               grant, mult_start, mult_data, busy);
    end
    tick();
    checks++;
    if (mult_data !== 16'h0007 || mult_start !== 1'b0) begin
      failures++; $display("FAIL single_load_m data=%h start=%b required 0007/0", mult_data, mult_start);
    end
    tick();
    checks++;
    if (mult_data !== 16'hFFFD) begin
      failures++; $display("FAIL single_load_q data=%h required fffd", mult_data);
    end
    tick();
    checks++;
    if (mult_data !== 16'h0 || grant !== 4'b0001) begin
      failures++; $display("FAIL single_busy data=%h grant=%b required 0000/0001", mult_data, grant);
    end
    wait_resp(who, prod, err, nt);
    req = '0;
    checks++;
    if (who != 0 || prod !== 32'hFFFFFFEB || err !== 1'b0 || nt != mdl_lat + 1) begin
      failures++;
      $display("FAIL single_resp who=%0d prod=%h err=%b busy_cycles=%0d required 0/ffffffeb/0/%0d",
               who, prod, err, nt, mdl_lat + 1);
    end
    tick();
    checks++;
    if (mult_rst !== 1'b1 || grant !== '0 || resp_valid !== '0 || resp_product !== 32'hFFFFFFEB) begin
      failures++;
      $display("FAIL single_recover mult_rst=%b grant=%b resp_valid=%b prod=%h required 1/0/0/ffffffeb",
               mult_rst, grant, resp_valid, resp_product);
    end
    tick();
    checks++;
    if (mult_rst !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_idle mult_rst=%b busy=%b required 0/0", mult_rst, busy);
    end
  endtask

  task automatic test_round_robin();
    int who, nt, exp; logic [2*W-1:0] prod; logic err;
    rst = 1'b1; tick(); tick(); rst = 1'b0; ref_rr = 0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = W'(i + 2);
    end
    req = '1;
    for (int n = 0; n < N + 1; n++) begin
      mdl_lat = $urandom_range(1, 8);
      exp = pick(req, ref_rr);
      wait_resp(who, prod, err, nt);
      checks++;
      if (who != exp || prod !== 32'((exp + 1) * (exp + 2)) || err !== 1'b0) begin
        failures++;
        $display("FAIL rr_job%0d who=%0d prod=%h err=%b required %0d/%h/0", n, who, prod, err,
                 exp, 32'((exp + 1) * (exp + 2)));
      end
      if (n != 0 && who >= 0) req[who] = 1'b0;
    end
    req = '0;
  endtask

  task automatic test_pointer_wrap();
    int who, nt, exp; logic [2*W-1:0] prod; logic err;
    idle_wait();
    mdl_lat = $urandom_range(1, 8);
    set_ops(2); req = 4'b0100;
    wait_resp(who, prod, err, nt);
    req = '0;
    checks++;
    if (who != 2 || prod !== exp_prod(2)) begin
      failures++; $display("FAIL wrap_setup who=%0d prod=%h required 2/%h", who, prod, exp_prod(2));
    end
    idle_wait();
    set_ops(0); set_ops(3); req = 4'b1001;
    for (int n = 0; n < 2; n++) begin
      exp = pick(req, ref_rr);
      wait_resp(who, prod, err, nt);
      checks++;
      if (who != exp || who != ((n == 0) ? 3 : 0) || prod !== exp_prod(exp) || err !== 1'b0) begin
        failures++;
        $display("FAIL wrap_job%0d who=%0d prod=%h err=%b required %0d/%h/0", n, who, prod, err,
                 exp, exp_prod(exp));
      end
      if (who >= 0) req[who] = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int who, nt; logic [2*W-1:0] prod; logic err;
    idle_wait();
    mdl_lat = -1; set_ops(1); req = 4'b0010;
    wait_resp(who, prod, err, nt);
    req = '0;
    checks++;
    if (who != 1 || err !== 1'b1 || prod !== '0 || nt - 4 != TO) begin
      failures++;
      $display("FAIL timeout_abort who=%0d err=%b prod=%h busy_cycles=%0d required 1/1/0/%0d",
               who, err, prod, nt - 4, TO);
    end
    idle_wait();
    mdl_lat = 5; req_a[1*W +: W] = 16'd5; req_b[1*W +: W] = 16'd5; req = 4'b0010;
    wait_resp(who, prod, err, nt);
    req = '0;
    checks++;
    if (who != 1 || err !== 1'b0 || prod !== 32'd25) begin
      failures++;
      $display("FAIL timeout_next who=%0d err=%b prod=%h required 1/0/00000019", who, err, prod);
    end
  endtask

  task automatic test_reset_mid_busy();
    int who, nt, exp; logic [2*W-1:0] prod; logic err; bit spurious;
    idle_wait();
    mdl_lat = -1; set_ops(3); req = 4'b1000;
    for (int c = 0; c < 14; c++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (mult_rst !== 1'b1 || resp_valid !== '0) begin
      failures++;
      $display("FAIL rstmid_assert mult_rst=%b resp_valid=%b required 1/0", mult_rst, resp_valid);
    end
    tick();
    checks++;
    if (grant !== '0 || busy !== 1'b0 || resp_valid !== '0 || mult_rst !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_state grant=%b busy=%b resp_valid=%b mult_rst=%b required 0/0/0/1",
               grant, busy, resp_valid, mult_rst);
    end
    rst = 1'b0; req = '0; ref_rr = 0;
    spurious = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (resp_valid !== '0 || busy !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      failures++; $display("FAIL rstmid_quiet spurious activity=1 required 0");
    end
    mdl_lat = $urandom_range(1, 8);
    for (int i = 0; i < N; i++) set_ops(i);
    req = '1;
    exp = pick(req, ref_rr);
    wait_resp(who, prod, err, nt);
    req = '0;
    checks++;
    if (who != exp || prod !== exp_prod(exp) || err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after who=%0d prod=%h err=%b required %0d/%h/0", who, prod, err, exp,
               exp_prod(exp));
    end
  endtask

  task automatic test_collision_stale();
    int who, nt; logic [2*W-1:0] prod; logic err; bit spurious;
    idle_wait();
    mdl_lat = TO - 1; set_ops(2); req = 4'b0100;
    wait_resp(who, prod, err, nt);
    req = '0;
    checks++;
    if (who != 2 || err !== 1'b0 || prod !== exp_prod(2) || nt - 4 != TO) begin
      failures++;
      $display("FAIL collision who=%0d err=%b prod=%h busy_cycles=%0d required 2/0/%h/%0d",
               who, err, prod, nt - 4, exp_prod(2), TO);
    end
    idle_wait();
    stale_done = 1'b1;
    spurious = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (resp_valid !== '0 || busy !== 1'b0) spurious = 1'b1;
    end
    stale_done = 1'b0;
    checks++;
    if (spurious) begin
      failures++; $display("FAIL stale_done spurious response=1 required 0");
    end
  endtask

  task automatic test_random();
    int who, nt, exp; logic [2*W-1:0] prod; logic err;
    for (int n = 0; n < 12; n++) begin
      idle_wait();
      for (int i = 0; i < N; i++) set_ops(i);
      mdl_lat = $urandom_range(1, 12);
      req = N'($urandom_range(1, (1 << N) - 1));
      exp = pick(req, ref_rr);
      wait_resp(who, prod, err, nt);
      req = '0;
      checks++;
      if (who != exp || prod !== exp_prod(exp) || err !== 1'b0 || nt - 4 != mdl_lat + 1) begin
        failures++;
        $display("FAIL random_job%0d who=%0d prod=%h err=%b busy_cycles=%0d required %0d/%h/0/%0d",
                 n, who, prod, err, nt - 4, exp, exp_prod(exp), mdl_lat + 1);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_pointer_wrap();
    test_timeout();
    test_reset_mid_busy();
    test_collision_stale();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
